c64_cia_timer: RTL and testbench
================================

# c64_cia_timer

Memory-mapped dual 16-bit interval timer that answers the 6502 core's bus as a responder: it decodes `ab`, takes write data from the CPU's `do`/`we`, and returns read data on the CPU's `di`. It provides the CIA-style timer A/B subset (latches, one-shot and continuous modes, B cascaded from A underflow) and a maskable interrupt line toward the CPU. It sits on the system bus beside RAM/ROM and is selected by the high address byte.

## Interface
- `BASE`, 16'hDC00, base address; block selected when `ab[15:8] == BASE[15:8]`, register index `ab[3:0]` (mirrored across the page)
- `clk`  in  1  system clock; one CPU bus cycle per edge; timers count on every edge
- `reset`  in  1  synchronous, active-high
- `ab`  in  16  CPU address bus
- `we`  in  1  CPU write enable; write committed at the `clk` edge where `we` is high and the block is selected
- `din`  in  8  write data (CPU `do`)
- `dout`  out  8  read data (CPU `di`); combinational from `ab` and register state
- `irq`  out  1  active-high interrupt request, registered

## Operation
- Register map (index): 4 TA_LO, 5 TA_HI, 6 TB_LO, 7 TB_HI, D ICR, E CRA, F CRB; all other indices read 8'h00 and ignore writes.
- TA/TB read: current counter byte. Write: latch byte. A write to _HI also loads counter from {new hi, latch lo} on that edge if the timer is stopped (START=0).
- CRx bits: 0 START, 3 ONESHOT, 4 FORCE_LOAD (strobe; reads 0; loads counter from latch on that edge). CRB bits 6:5: 00 count clk, 10 count TA underflows, others behave as 00. Unused bits stored and read back.
- Counting: when START=1 and count enable true, counter decrements. Decrement from 16'h0000 is an underflow: counter reloads latch (no wrap to FFFF), flag bit set, and if ONESHOT then START clears on the same edge.
- TA underflow pulse is one cycle; TB in cascade mode decrements only in that cycle.
- ICR write: bit 7 = 1 sets mask bits where din[1:0]=1; bit 7 = 0 clears them. ICR read: {irq, 5'b0, flags[1:0]}; the read clears flags. Any cycle with ICR selected and `we`=0 is a read.
- `irq` = |(flags & mask), registered on the edge after the flag/mask change; falls on the edge after the clearing read.

## Timing
- Reset (synchronous): latches 16'hFFFF, counters 16'hFFFF, CRA/CRB 0, mask 0, flags 0, `irq` 0; `dout` 8'h00 while `reset` high.
- Read latency 0: `dout` valid in the same cycle as `ab`, sampled by CPU at the next edge.
- Write latency 1: register value visible on `dout` the cycle after the write edge.
- Underflow at edge N: flag set at N, `irq` high after edge N+1.
- Simultaneous events: underflow + ICR read in same edge → flag remains set (event wins), read returns pre-edge value. FORCE_LOAD + underflow → counter takes latch, flag still set. Writing CRA with START=1 and FORCE_LOAD=1 → counter loads, decrement starts next edge. Write to _HI while running → latch only.
- Reset mid-count overrides all pending writes and underflows.

## Structure
- Shared package `c64_cia_pkg`: register index constants, CR bit positions, CRB input-mode encoding, reset latch value.
- One sub-module `cia_timer_unit` (latch, counter, START/ONESHOT control, underflow pulse, count-enable input), instantiated twice; top holds decode, ICR, mask, `irq`, read mux.

## Test plan
- Reset, then read DC04/DC05/DC0D → FF, FF, 00; `irq` 0.
- Write DC04=03, DC05=00, DC0D=81, DC0E=09 → TA counts 3,2,1,0, underflow on 4th edge, START clears, DC0E reads 08, `irq` rises one edge later; read DC0D → 81, then next read → 00 and `irq` falls.
- Continuous mode latch 0002, START=1 → underflow every 3 cycles, counter reloads 0002, never reads FFFF.
- Cascade: TA latch 0001 continuous, TB latch 0002 with CRB=41 → TB underflows once per 6 clocks; flag bit 1 set, `irq` stays 0 with mask 0.
- Underflow coincident with ICR read → read returns 00, next read returns 01; write to DC05 while running leaves counter unaffected.
- Assert `reset` mid-count with `irq` high → next edge all registers at reset values, `irq` 0.

Source files
------------

// File: rtl/c64_cia_pkg.sv
// Shared constants for the CIA-style timer block: register indices, control bit
// positions, cascade mode encoding and the reset latch value.
package c64_cia_pkg;

  localparam logic [3:0] REG_TA_LO = 4'h4;
  localparam logic [3:0] REG_TA_HI = 4'h5;
  localparam logic [3:0] REG_TB_LO = 4'h6;
  localparam logic [3:0] REG_TB_HI = 4'h7;
  localparam logic [3:0] REG_ICR   = 4'hD;
  localparam logic [3:0] REG_CRA   = 4'hE;
  localparam logic [3:0] REG_CRB   = 4'hF;

  localparam int unsigned CR_START      = 0;
  localparam int unsigned CR_ONESHOT    = 3;
  localparam int unsigned CR_FORCE_LOAD = 4;

  localparam logic [1:0] CRB_MODE_CLK = 2'b00;
  localparam logic [1:0] CRB_MODE_TA  = 2'b10;

  localparam logic [15:0] LATCH_RESET = 16'hFFFF;

  // FORCE_LOAD is a write strobe only, so it is never kept in the stored control byte.
  function automatic logic [7:0] crStore(input logic [7:0] d);
    logic [7:0] v;
    v = d;
    v[CR_FORCE_LOAD] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/c64_cia_timer_unit.sv
// One 16-bit interval timer: latch, down counter, control byte and a
// single-cycle underflow indication that is true in the cycle the edge reloads.
module cia_timer_unit
  import c64_cia_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_countEn,
  input  logic        i_wrLo,
  input  logic        i_wrHi,
  input  logic        i_wrCr,
  input  logic [7:0]  i_din,
  output logic [15:0] o_counter,
  output logic [7:0]  o_cr,
  output logic        o_underflow
);

  logic [15:0] r_latch;
  logic [15:0] r_counter;
  logic [7:0]  r_cr;

  logic w_start;
  logic w_forceLoad;
  logic w_count;
  logic w_underflow;

  assign w_start     = r_cr[CR_START];
  assign w_forceLoad = i_wrCr & i_din[CR_FORCE_LOAD];
  assign w_count     = w_start & i_countEn;
  assign w_underflow = w_count & (r_counter == 16'h0000);

  // Underflow is judged on pre-edge state, so a coincident load still reports it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_latch   <= LATCH_RESET;
      r_counter <= LATCH_RESET;
      r_cr      <= 8'h00;
    end else begin
      if (i_wrLo) r_latch[7:0]  <= i_din;
      if (i_wrHi) r_latch[15:8] <= i_din;

      if (w_forceLoad)
        r_counter <= r_latch;
      else if (i_wrHi && !w_start)
        r_counter <= {i_din, r_latch[7:0]};
      else if (w_underflow)
        r_counter <= r_latch;
      else if (w_count)
        r_counter <= r_counter - 16'd1;

      if (i_wrCr)
        r_cr <= crStore(i_din);
      else if (w_underflow && r_cr[CR_ONESHOT])
        r_cr[CR_START] <= 1'b0;
    end
  end

  assign o_counter   = r_counter;
  assign o_cr        = r_cr;
  assign o_underflow = w_underflow;

endmodule

// File: rtl/c64_cia_timer.sv
// Bus-mapped dual timer: page decode, two timer units (B optionally cascaded
// from A), interrupt flags/mask, registered irq and the combinational read mux.
module c64_cia_timer
  import c64_cia_pkg::*;
#(
  parameter logic [15:0] BASE = 16'hDC00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ab,
  input  logic        we,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        irq
);

  logic       w_sel;
  logic [3:0] w_idx;
  logic       w_wr;
  logic       w_icrRead;

  logic [15:0] w_taCounter;
  logic [15:0] w_tbCounter;
  logic [7:0]  w_cra;
  logic [7:0]  w_crb;
  logic        w_taUnderflow;
  logic        w_tbUnderflow;
  logic        w_tbCountEn;

  logic [1:0] r_flags;
  logic [1:0] r_mask;
  logic       r_irq;

  assign w_sel     = (ab[15:8] == BASE[15:8]);
  assign w_idx     = ab[3:0];
  assign w_wr      = w_sel & we;
  assign w_icrRead = w_sel & ~we & (w_idx == REG_ICR);

  // Only mode 10 cascades; every other mode counts system clocks.
  assign w_tbCountEn = (w_crb[6:5] == CRB_MODE_TA) ? w_taUnderflow : 1'b1;

  cia_timer_unit u_timerA (
    .clk         (clk),
    .reset       (reset),
    .i_countEn   (1'b1),
    .i_wrLo      (w_wr && (w_idx == REG_TA_LO)),
    .i_wrHi      (w_wr && (w_idx == REG_TA_HI)),
    .i_wrCr      (w_wr && (w_idx == REG_CRA)),
    .i_din       (din),
    .o_counter   (w_taCounter),
    .o_cr        (w_cra),
    .o_underflow (w_taUnderflow)
  );

  cia_timer_unit u_timerB (
    .clk         (clk),
    .reset       (reset),
    .i_countEn   (w_tbCountEn),
    .i_wrLo      (w_wr && (w_idx == REG_TB_LO)),
    .i_wrHi      (w_wr && (w_idx == REG_TB_HI)),
    .i_wrCr      (w_wr && (w_idx == REG_CRB)),
    .i_din       (din),
    .o_counter   (w_tbCounter),
    .o_cr        (w_crb),
    .o_underflow (w_tbUnderflow)
  );

  // New underflow events are OR-ed after the read clear so an event never gets lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 2'b00;
      r_mask  <= 2'b00;
      r_irq   <= 1'b0;
    end else begin
      r_flags <= (w_icrRead ? 2'b00 : r_flags) | {w_tbUnderflow, w_taUnderflow};
      if (w_wr && (w_idx == REG_ICR))
        r_mask <= din[7] ? (r_mask | din[1:0]) : (r_mask & ~din[1:0]);
      r_irq <= |(r_flags & r_mask);
    end
  end

  always_comb begin
    dout = 8'h00;
    if (!reset && w_sel) begin
      case (w_idx)
        REG_TA_LO: dout = w_taCounter[7:0];
        REG_TA_HI: dout = w_taCounter[15:8];
        REG_TB_LO: dout = w_tbCounter[7:0];
        REG_TB_HI: dout = w_tbCounter[15:8];
        REG_ICR:   dout = {r_irq, 5'b00000, r_flags};
        REG_CRA:   dout = w_cra;
        REG_CRB:   dout = w_crb;
        default:   dout = 8'h00;
      endcase
    end
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_c64_cia_timer.sv
// Directed bench for c64_cia_timer: bus reads/writes with hand-computed
// expectations for one-shot, continuous, cascade, coincidence and reset cases.
module tb_c64_cia_timer;

  localparam logic [15:0] BASE = 16'hDC00;

  logic        clk;
  logic        reset;
  logic [15:0] ab;
  logic        we;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  c64_cia_timer #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .ab    (ab),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle: drive address/data, commit on the next edge, then idle the bus.
  task automatic applyStimulus(input logic [3:0] idx, input logic [7:0] d);
    ab  = {BASE[15:8], 4'h0, idx};
    we  = 1'b1;
    din = d;
    tick();
    we  = 1'b0;
    ab  = 16'h0000;
  endtask

  task automatic readReg(input logic [3:0] idx, output logic [7:0] v);
    ab = {BASE[15:8], 4'h0, idx};
    we = 1'b0;
    #1 v = dout;
    tick();
    ab = 16'h0000;
  endtask

  logic [7:0] v;
  logic [7:0] cascadeExp [12];

  initial begin
    cascadeExp = '{8'h02, 8'h02, 8'h01, 8'h01, 8'h00, 8'h00,
                   8'h02, 8'h02, 8'h01, 8'h01, 8'h00, 8'h00};
    reset = 1'b1;
    ab    = 16'h0000;
    we    = 1'b0;
    din   = 8'h00;
    tick();
    tick();
    ab = 16'hDC04;
    #1 checkOutput("doutInReset", {8'h00, dout}, 16'h0000);
    reset = 1'b0;
    ab    = 16'h0000;

    readReg(4'h4, v); checkOutput("rstTaLo", {8'h00, v}, 16'h00FF);
    readReg(4'h5, v); checkOutput("rstTaHi", {8'h00, v}, 16'h00FF);
    readReg(4'hD, v); checkOutput("rstIcr",  {8'h00, v}, 16'h0000);
    checkOutput("rstIrq", {15'h0, irq}, 16'h0000);

    // One-shot: latch 0003, mask TA, start + oneshot.
    applyStimulus(4'h4, 8'h03);
    applyStimulus(4'h5, 8'h00);
    applyStimulus(4'hD, 8'h81);
    applyStimulus(4'hE, 8'h09);
    for (int i = 0; i < 4; i++) begin
      ab = 16'hDC04;
      #1 checkOutput($sformatf("oneShotCnt%0d", i), {8'h00, dout}, 16'(3 - i));
      tick();
    end
    checkOutput("oneShotIrqLate", {15'h0, irq}, 16'h0000);
    ab = 16'hDC0E;
    #1 checkOutput("oneShotCraStop", {8'h00, dout}, 16'h0008);
    ab = 16'hDC04;
    #1 checkOutput("oneShotReload", {8'h00, dout}, 16'h0003);
    tick();
    checkOutput("oneShotIrqRise", {15'h0, irq}, 16'h0001);
    readReg(4'hD, v); checkOutput("oneShotIcr", {8'h00, v}, 16'h0081);
    checkOutput("irqHoldAfterRead", {15'h0, irq}, 16'h0001);
    tick();
    checkOutput("irqFall", {15'h0, irq}, 16'h0000);
    readReg(4'hD, v); checkOutput("icrCleared", {8'h00, v}, 16'h0000);

    // Continuous: latch 0002, mask cleared.
    applyStimulus(4'hD, 8'h03);
    applyStimulus(4'h4, 8'h02);
    applyStimulus(4'h5, 8'h00);
    applyStimulus(4'hE, 8'h01);
    for (int i = 0; i < 9; i++) begin
      ab = 16'hDC04;
      #1 checkOutput($sformatf("contLo%0d", i), {8'h00, dout}, 16'(2 - (i % 3)));
      tick();
    end
    ab = 16'hDC05;
    #1 checkOutput("contHi", {8'h00, dout}, 16'h0000);
    tick();
    applyStimulus(4'hE, 8'h00);
    readReg(4'hD, v); checkOutput("contFlag", {8'h00, v}, 16'h0001);

    // Cascade: TA latch 0001 continuous, TB latch 0002 counting TA underflows.
    applyStimulus(4'h4, 8'h01);
    applyStimulus(4'h5, 8'h00);
    applyStimulus(4'h6, 8'h02);
    applyStimulus(4'h7, 8'h00);
    applyStimulus(4'hF, 8'h41);
    applyStimulus(4'hE, 8'h01);
    for (int k = 0; k < 12; k++) begin
      ab = 16'hDC06;
      #1 checkOutput($sformatf("cascTb%0d", k), {8'h00, dout}, {8'h00, cascadeExp[k]});
      tick();
    end
    checkOutput("cascIrqMasked", {15'h0, irq}, 16'h0000);
    readReg(4'hD, v); checkOutput("cascIcr", {8'h00, v}, 16'h0003);
    applyStimulus(4'hE, 8'h00);
    applyStimulus(4'hF, 8'h00);

    // Underflow coincident with ICR read.
    applyStimulus(4'h4, 8'h02);
    applyStimulus(4'h5, 8'h00);
    readReg(4'hD, v);
    applyStimulus(4'hE, 8'h01);
    tick();
    tick();
    readReg(4'hD, v); checkOutput("coincRead", {8'h00, v}, 16'h0000);
    readReg(4'hD, v); checkOutput("coincNext", {8'h00, v}, 16'h0001);
    applyStimulus(4'h5, 8'h12);
    readReg(4'h5, v); checkOutput("hiWriteRunning", {8'h00, v}, 16'h0000);
    readReg(4'h5, v); checkOutput("hiLatchReload", {8'h00, v}, 16'h0012);

    // FORCE_LOAD with START while running.
    applyStimulus(4'hE, 8'h11);
    readReg(4'h4, v); checkOutput("forceLoadLo", {8'h00, v}, 16'h0002);
    readReg(4'hE, v); checkOutput("forceLoadCra", {8'h00, v}, 16'h0001);

    // Reset in the middle of counting with irq asserted.
    applyStimulus(4'hD, 8'h81);
    applyStimulus(4'h4, 8'h01);
    applyStimulus(4'h5, 8'h00);
    applyStimulus(4'hE, 8'h11);
    repeat (4) tick();
    checkOutput("preResetIrq", {15'h0, irq}, 16'h0001);
    reset = 1'b1;
    ab    = 16'hDC0E;
    we    = 1'b1;
    din   = 8'hFF;
    tick();
    we = 1'b0;
    #1 checkOutput("resetDoutHigh", {8'h00, dout}, 16'h0000);
    checkOutput("resetIrq", {15'h0, irq}, 16'h0000);
    reset = 1'b0;
    ab    = 16'h0000;
    readReg(4'hE, v); checkOutput("postRstCra",  {8'h00, v}, 16'h0000);
    readReg(4'h4, v); checkOutput("postRstTaLo", {8'h00, v}, 16'h00FF);
    readReg(4'h5, v); checkOutput("postRstTaHi", {8'h00, v}, 16'h00FF);
    readReg(4'hD, v); checkOutput("postRstIcr",  {8'h00, v}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
